lstm_seq_driver: RTL
====================

# lstm_seq_driver

Sequential driver for the combinational LSTM cell. It accepts a stream of input samples X and presents each one to the cell together with the registered previous state (c, h). It captures the cell's c_out/h_out after a fixed settle window and feeds them back as the next c_in/h_in. It also emits one h per time step on a valid/ready output stream. The cell consumes (c_in, h_in, X) and produces (c_out, h_out); this block is the opposite end of that interface.

## Interface
- DATA_WIDTH, 16, width of all data words (signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH)
- FRACT_WIDTH, 8, fractional bits; used only for documentation and the bench model (no arithmetic in this block)
- SEQ_LEN_W, 8, width of sequence-length and step counters
- SETTLE_CYCLES, 2, cycles the cell inputs are held stable before capture; legal range ≥1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sequence; ignored while busy
- seq_len  in  SEQ_LEN_W  number of time steps; sampled with start
- c_init, h_init  in  DATA_WIDTH  initial cell/hidden state; sampled with start
- x_valid  in  1  input sample valid
- x_data  in  DATA_WIDTH  input sample X
- x_ready  out  1  driver can accept a sample
- cell_x, cell_c_in, cell_h_in  out  DATA_WIDTH  registered drive to the cell's X, c_in and h_in
- cell_c_out, cell_h_out  in  DATA_WIDTH  combinational results from the cell
- h_valid  out  1  output h valid
- h_data  out  DATA_WIDTH  hidden state for the current step
- h_last  out  1  qualifies h_valid on the final step
- h_ready  in  1  downstream accepts h
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence completion
- c_final  out  DATA_WIDTH  cell state after the last completed step; holds until the next start

## Operation
- States: IDLE, LOAD, SETTLE, EMIT.
- IDLE:
  - start with seq_len≠0: load c_reg←c_init, h_reg←h_init, step←0, then go to LOAD.
  - start with seq_len=0: pulse done on the next cycle, stay in IDLE, leave c_final unchanged.
- LOAD:
  - x_ready=1.
  - On x_valid&x_ready: x_reg←x_data, settle counter←0, then go to SETTLE.
- SETTLE:
  - cell_x=x_reg, cell_c_in=c_reg and cell_h_in=h_reg are held constant.
  - Counter increments once per cycle.
  - On the cycle where counter=SETTLE_CYCLES-1: c_reg←cell_c_out, h_reg←cell_h_out, h_data←cell_h_out, c_final←cell_c_out, then go to EMIT.
- EMIT:
  - h_valid=1; h_last=1 iff step=seq_len-1.
  - On h_ready, if h_last: done pulses, go to IDLE.
  - On h_ready, otherwise: step←step+1, go to LOAD.
- cell_* outputs are driven by registers only, never combinationally from inputs.
- Data is passed bit-exact; no rounding, saturation or sign handling in this block.
- seq_len and the init values are not re-sampled mid-sequence.

## Timing
- Reset values:
  - State IDLE.
  - x_ready, h_valid, h_last, busy, done = 0.
  - h_data, c_final, cell_x, cell_c_in, cell_h_in, internal registers = 0.
- Sample accepted at edge T → h_valid high from cycle T+SETTLE_CYCLES+1.
- Minimum period is SETTLE_CYCLES+2 cycles per step (with x_valid and h_ready held high).
- start → x_ready high on the next cycle.
- h_valid stays high and h_data/h_last are stable until h_ready is sampled high. x_ready is 0 throughout EMIT and SETTLE.
- done asserts in the cycle after the final h handshake, for exactly one cycle; busy falls in that same cycle.
- start asserted in the same cycle done is high is accepted, because the state is IDLE.
- Asserting rst at any point, including mid-SETTLE or mid-EMIT, aborts the sequence immediately. All outputs return to their reset values and no done pulse is produced.
- seq_len = 2^SEQ_LEN_W-1 must complete without the step counter wrapping.

## Test plan
- Reset: assert rst mid-cycle → every output is 0 asynchronously; busy=0 after release.
- Single step: SETTLE_CYCLES=2, seq_len=1, c_init=h_init=0, x=0x0100 accepted at edge T, cell model returns c=0x0080/h=0x0040 → h_valid at T+3 with h_data=0x0040 and h_last=1. After the handshake, done pulses once and c_final=0x0080.
- Feedback: seq_len=3, x=0x0100,0x0200,0x0300 → cell_c_in/cell_h_in in steps 2 and 3 equal the c_out/h_out captured in the previous step; only step 3 has h_last=1; exactly 3 h handshakes.
- Backpressure: hold h_ready low for 5 cycles in EMIT → h_valid, h_data and h_last stay stable, x_ready stays 0, and the step does not advance. Releasing h_ready completes the step.
- Zero length and busy start:
  - start with seq_len=0 → done on the next cycle; x_ready and h_valid never assert.
  - start pulsed during SETTLE → ignored; seq_len/c_init are unchanged.
- Reset mid-sequence: rst during SETTLE of step 2 → IDLE with all outputs 0 and no done pulse. A new seq_len=1 run afterwards completes correctly.

Source files
------------

// File: rtl/lstm_seq_driver.sv
// lstm_seq_driver: steps a combinational LSTM cell through a sequence of
// input samples. Each sample is held against the cell for a settle window.
// The cell's result is then captured as the next state and emitted as one h
// per step on a valid/ready stream.
module lstm_seq_driver #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRACT_WIDTH   = 8,
    parameter int SEQ_LEN_W     = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic        [SEQ_LEN_W-1:0]  seq_len,
    input  logic signed [DATA_WIDTH-1:0] c_init,
    input  logic signed [DATA_WIDTH-1:0] h_init,
    input  logic                         x_valid,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    output logic                         x_ready,
    output logic signed [DATA_WIDTH-1:0] cell_x,
    output logic signed [DATA_WIDTH-1:0] cell_c_in,
    output logic signed [DATA_WIDTH-1:0] cell_h_in,
    input  logic signed [DATA_WIDTH-1:0] cell_c_out,
    input  logic signed [DATA_WIDTH-1:0] cell_h_out,
    output logic                         h_valid,
    output logic signed [DATA_WIDTH-1:0] h_data,
    output logic                         h_last,
    input  logic                         h_ready,
    output logic                         busy,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] c_final
);

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // Reject parameter sets that make the settle window or the Q format meaningless.
    if (SETTLE_CYCLES < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_params
        $error("lstm_seq_driver: illegal parameter values");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, EMIT} state_t;

    state_t               state, state_next;
    logic [SEQ_LEN_W-1:0] len_reg;
    logic [SEQ_LEN_W-1:0] step;
    logic [CNT_W-1:0]     cnt;
    logic                 done_next;
    logic                 seq_go;
    logic                 settle_end;
    logic                 last_step;

    assign seq_go     = (state == IDLE) && start && (seq_len != '0);
    assign settle_end = (state == SETTLE) && (cnt == CNT_W'(SETTLE_CYCLES - 1));
    // len_reg is never 0 inside a sequence, so step never passes len_reg-1 and cannot wrap.
    assign last_step  = (step == len_reg - SEQ_LEN_W'(1));

    // State register and the one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Next-state logic and the handshake/status outputs decoded from the state.
    always_comb begin
        state_next = state;
        x_ready    = 1'b0;
        h_valid    = 1'b0;
        h_last     = 1'b0;
        busy       = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (seq_len != '0) state_next = LOAD;
                    else               done_next  = 1'b1;
                end
            end
            LOAD: begin
                x_ready = 1'b1;
                if (x_valid) state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_end) state_next = EMIT;
            end
            EMIT: begin
                h_valid = 1'b1;
                h_last  = last_step;
                if (h_ready) begin
                    if (last_step) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sequence length, step index and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg <= '0;
            step    <= '0;
            cnt     <= '0;
        end else begin
            if (seq_go) begin
                len_reg <= seq_len;
                step    <= '0;
            end
            if (state == LOAD && x_valid) cnt <= '0;
            if (state == SETTLE)          cnt <= cnt + CNT_W'(1);
            if (state == EMIT && h_ready && !last_step) step <= step + SEQ_LEN_W'(1);
        end
    end

    // Cell drive registers, recurrent state capture and the emitted h / final c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_x    <= '0;
            cell_c_in <= '0;
            cell_h_in <= '0;
            h_data    <= '0;
            c_final   <= '0;
        end else begin
            if (seq_go) begin
                cell_c_in <= c_init;
                cell_h_in <= h_init;
            end
            if (state == LOAD && x_valid) cell_x <= x_data;
            if (settle_end) begin
                cell_c_in <= cell_c_out;
                cell_h_in <= cell_h_out;
                h_data    <= cell_h_out;
                c_final   <= cell_c_out;
            end
        end
    end

endmodule
